// File: rtl/mux_scan.sv
// rtl/mux_scan.sv - registered N-channel mux with manual select and auto-scan
module mux_scan #(
    parameter int WIDTH = 4,
    parameter int CH    = 4,
    parameter int DWELL = 4,
    localparam int SEL_W = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [CH*WIDTH-1:0]   d,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      q,
    output logic [SEL_W-1:0]      q_sel,
    output logic                  q_valid,
    output logic                  wrap
);

    localparam int DC_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MANUAL = 2'd1;
    localparam logic [1:0] SCAN   = 2'd2;

    localparam logic [SEL_W:0]   CH_N   = (SEL_W+1)'(CH);
    localparam logic [SEL_W-1:0] CH_MAX = SEL_W'(CH - 1);
    localparam logic [DC_W-1:0]  DC_MAX = DC_W'(DWELL - 1);

    logic [1:0]       state;
    logic [SEL_W-1:0] ch;
    logic [DC_W-1:0]  dc;

    logic             in_range;
    logic             entering;
    logic             expire;
    logic             last_ch;
    logic [SEL_W-1:0] load_ch;
    logic [SEL_W-1:0] idx;
    logic [WIDTH-1:0] pick;

    // idx is the channel that this edge samples; in scan it is also the new ch
    always_comb begin
        in_range = ({1'b0, sel} < CH_N);
        entering = (state != SCAN);
        expire   = (dc == DC_MAX);
        last_ch  = (ch == CH_MAX);
        load_ch  = in_range ? sel : '0;
        if (!mode)
            idx = sel;
        else if (entering)
            idx = load_ch;
        else if (expire)
            idx = last_ch ? '0 : ch + SEL_W'(1);
        else
            idx = ch;
    end

    // Out-of-range indices match no channel and therefore yield zero
    always_comb begin
        pick = '0;
        for (int k = 0; k < CH; k++) begin
            if (idx == SEL_W'(k))
                pick = d[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ch      <= '0;
            dc      <= '0;
            q       <= '0;
            q_sel   <= '0;
            q_valid <= 1'b0;
            wrap    <= 1'b0;
        end else if (en) begin
            wrap <= 1'b0;
            q    <= pick;
            if (!mode) begin
                state   <= MANUAL;
                q_sel   <= sel;
                q_valid <= in_range;
            end else begin
                state   <= SCAN;
                q_sel   <= idx;
                q_valid <= 1'b1;
                if (entering) begin
                    ch <= load_ch;
                    dc <= '0;
                end else if (expire) begin
                    ch   <= idx;
                    dc   <= '0;
                    wrap <= last_ch;
                end else begin
                    dc <= dc + DC_W'(1);
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// tb/tb_mux_scan.sv - scoreboard bench for mux_scan (CH=4 and CH=3 instances)
module tb_mux_scan;

    typedef struct packed {
        logic [3:0] q;
        logic [1:0] s;
        logic       v;
        logic       w;
    } obs_t;

    typedef struct packed {
        logic e;
        logic m;
        logic [1:0] s;
        obs_t x;
    } step_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, mode = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [15:0] d = 16'hF5A3;
    logic [3:0]  q;
    logic [1:0]  q_sel;
    logic        q_valid, wrap;

    logic        en3 = 1'b0, mode3 = 1'b0;
    logic [1:0]  sel3 = 2'd0;
    logic [11:0] d3 = 12'h5A3;
    logic [3:0]  q3;
    logic [1:0]  q_sel3;
    logic        q_valid3, wrap3;

    obs_t exp_q[$];
    obs_t exp3_q[$];
    obs_t got, want;
    int   n_cmp = 0;
    int   n_bad = 0;

    mux_scan #(.WIDTH(4), .CH(4), .DWELL(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .sel(sel),
        .q(q), .q_sel(q_sel), .q_valid(q_valid), .wrap(wrap)
    );

    mux_scan #(.WIDTH(4), .CH(3), .DWELL(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .d(d3), .sel(sel3),
        .q(q3), .q_sel(q_sel3), .q_valid(q_valid3), .wrap(wrap3)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic step_t mk(input logic e, input logic m, input logic [1:0] s,
                                 input logic [3:0] xq, input logic [1:0] xs,
                                 input logic xv, input logic xw);
        step_t t;
        t.e = e; t.m = m; t.s = s;
        t.x = '{q: xq, s: xs, v: xv, w: xw};
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        exp_q.push_back(obs_t'(8'h00));
        exp3_q.push_back(obs_t'(8'h00));
        want = exp_q.pop_front();
        got = {q, q_sel, q_valid, wrap};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL reset_main: got %h need %h", got, want);
        end
        want = exp3_q.pop_front();
        got = {q3, q_sel3, q_valid3, wrap3};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL reset_ch3: got %h need %h", got, want);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(obs_t'(8'h00));
        tick();
        want = exp_q.pop_front();
        got = {q, q_sel, q_valid, wrap};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL idle_en0: got %h need %h", got, want);
        end
    endtask

    task automatic test_manual();
        step_t t[4];
        t[0] = mk(1, 0, 0, 4'h3, 0, 1, 0);
        t[1] = mk(1, 0, 1, 4'hA, 1, 1, 0);
        t[2] = mk(1, 0, 2, 4'h5, 2, 1, 0);
        t[3] = mk(1, 0, 3, 4'hF, 3, 1, 0);
        for (int i = 0; i < 4; i++) begin
            en = t[i].e; mode = t[i].m; sel = t[i].s;
            exp_q.push_back(t[i].x);
            tick();
            want = exp_q.pop_front();
            got = {q, q_sel, q_valid, wrap};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL manual[%0d]: q/sel/v/w got %h/%0d/%b/%b need %h/%0d/%b/%b",
                         i, got.q, got.s, got.v, got.w, want.q, want.s, want.v, want.w);
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] eq [9] = '{4'h5, 4'h5, 4'hF, 4'hF, 4'h3, 4'h3, 4'hA, 4'hA, 4'h5};
        logic [1:0] es [9] = '{2, 2, 3, 3, 0, 0, 1, 1, 2};
        for (int i = 0; i < 9; i++) begin
            en = 1'b1; mode = 1'b1; sel = 2'd2;
            exp_q.push_back(mk(1, 1, 2, eq[i], es[i], 1, (i == 4)).x);
            tick();
            want = exp_q.pop_front();
            got = {q, q_sel, q_valid, wrap};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL scan[%0d]: q/sel/v/w got %h/%0d/%b/%b need %h/%0d/%b/%b",
                         i, got.q, got.s, got.v, got.w, want.q, want.s, want.v, want.w);
            end
        end
    endtask

    task automatic test_enable_hold();
        step_t t[10];
        t[0] = mk(0, 1, 2, 4'h5, 2, 1, 0);
        t[1] = mk(0, 1, 2, 4'h5, 2, 1, 0);
        t[2] = mk(0, 1, 2, 4'h5, 2, 1, 0);
        t[3] = mk(1, 1, 2, 4'h5, 2, 1, 0);
        t[4] = mk(1, 1, 2, 4'hF, 3, 1, 0);
        t[5] = mk(1, 1, 2, 4'hF, 3, 1, 0);
        t[6] = mk(1, 1, 2, 4'h3, 0, 1, 1);
        t[7] = mk(0, 1, 2, 4'h3, 0, 1, 0);
        t[8] = mk(1, 1, 2, 4'h3, 0, 1, 0);
        t[9] = mk(1, 1, 2, 4'hA, 1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            en = t[i].e; mode = t[i].m; sel = t[i].s;
            exp_q.push_back(t[i].x);
            tick();
            want = exp_q.pop_front();
            got = {q, q_sel, q_valid, wrap};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL hold[%0d]: q/sel/v/w got %h/%0d/%b/%b need %h/%0d/%b/%b",
                         i, got.q, got.s, got.v, got.w, want.q, want.s, want.v, want.w);
            end
        end
    endtask

    task automatic test_mode_collision();
        step_t t[9];
        t[0] = mk(1, 1, 2, 4'hA, 1, 1, 0);
        t[1] = mk(1, 1, 2, 4'h5, 2, 1, 0);
        t[2] = mk(1, 1, 2, 4'h5, 2, 1, 0);
        t[3] = mk(1, 1, 2, 4'hF, 3, 1, 0);
        t[4] = mk(1, 1, 2, 4'hF, 3, 1, 0);
        t[5] = mk(1, 0, 1, 4'hA, 1, 1, 0);
        t[6] = mk(1, 1, 3, 4'hF, 3, 1, 0);
        t[7] = mk(1, 1, 3, 4'hF, 3, 1, 0);
        t[8] = mk(1, 1, 3, 4'h3, 0, 1, 1);
        for (int i = 0; i < 9; i++) begin
            en = t[i].e; mode = t[i].m; sel = t[i].s;
            exp_q.push_back(t[i].x);
            tick();
            want = exp_q.pop_front();
            got = {q, q_sel, q_valid, wrap};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL collision[%0d]: q/sel/v/w got %h/%0d/%b/%b need %h/%0d/%b/%b",
                         i, got.q, got.s, got.v, got.w, want.q, want.s, want.v, want.w);
            end
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(obs_t'(8'h00));
        want = exp_q.pop_front();
        got = {q, q_sel, q_valid, wrap};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL async_reset: got %h need %h", got, want);
        end
        #1;
        rst_n = 1'b1;
        en = 1'b1; mode = 1'b0; sel = 2'd1;
        exp_q.push_back(mk(1, 0, 1, 4'hA, 1, 1, 0).x);
        tick();
        want = exp_q.pop_front();
        got = {q, q_sel, q_valid, wrap};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL after_reset: q/sel/v/w got %h/%0d/%b/%b need %h/%0d/%b/%b",
                     got.q, got.s, got.v, got.w, want.q, want.s, want.v, want.w);
        end
    endtask

    task automatic test_out_of_range();
        step_t t[10];
        t[0] = mk(1, 0, 3, 4'h0, 3, 0, 0);
        t[1] = mk(1, 0, 2, 4'h5, 2, 1, 0);
        t[2] = mk(1, 0, 3, 4'h0, 3, 0, 0);
        t[3] = mk(1, 1, 3, 4'h3, 0, 1, 0);
        t[4] = mk(1, 1, 3, 4'h3, 0, 1, 0);
        t[5] = mk(1, 1, 3, 4'hA, 1, 1, 0);
        t[6] = mk(1, 1, 3, 4'hA, 1, 1, 0);
        t[7] = mk(1, 1, 3, 4'h5, 2, 1, 0);
        t[8] = mk(1, 1, 3, 4'h5, 2, 1, 0);
        t[9] = mk(1, 1, 3, 4'h3, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            en3 = t[i].e; mode3 = t[i].m; sel3 = t[i].s;
            exp3_q.push_back(t[i].x);
            tick();
            want = exp3_q.pop_front();
            got = {q3, q_sel3, q_valid3, wrap3};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL ch3_range[%0d]: q/sel/v/w got %h/%0d/%b/%b need %h/%0d/%b/%b",
                         i, got.q, got.s, got.v, got.w, want.q, want.s, want.v, want.w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_scan();
        test_enable_hold();
        test_mode_collision();
        test_async_reset();
        test_out_of_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_scan.md
# mux_scan

Parametrised, registered N-channel multiplexer with a manual-select mode and an auto-scan mode. It replaces the combinational 4:1 bit mux where a selected channel must be sampled on a clock edge. In scan mode an internal channel counter walks all channels, dwelling a programmable number of cycles on each. It sits between multi-channel sources and a single downstream sampler/monitor.

## Interface
Parameters:
- WIDTH, 4: bits per channel.
- CH, 4: number of channels, 2..16.
- DWELL, 4: cycles spent on each channel in scan mode, ≥1.
- SEL_W, $clog2(CH): local, not overridable; select width.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- en  in  1  enable; when 0 all state holds.
- mode  in  1  0 = manual, 1 = scan.
- d  in  CH*WIDTH  packed channels; channel k = d[k*WIDTH +: WIDTH].
- sel  in  SEL_W  manual channel select, also the scan start channel.
- q  out  WIDTH  registered selected data.
- q_sel  out  SEL_W  channel index that produced the current q.
- q_valid  out  1  q holds a legal sample.
- wrap  out  1  one-cycle pulse when the scan counter returns from CH-1 to 0.

## Operation
- FSM states: IDLE, MANUAL, SCAN.
- Reset: state = IDLE, q = 0, q_sel = 0, q_valid = 0, wrap = 0, channel counter ch = 0, dwell counter dc = 0.
- IDLE: on the first edge with en=1, go to MANUAL (mode=0) or SCAN (mode=1). That same edge performs the first sample, as in the target state.
- MANUAL, each en=1 edge:
  - If sel < CH: q ← d[sel], q_sel ← sel, q_valid ← 1.
  - If sel ≥ CH (non-power-of-2 CH): q ← 0, q_sel ← sel, q_valid ← 0.
- SCAN, each en=1 edge: q ← d[ch], q_sel ← ch, q_valid ← 1.
  - dc increments. When dc = DWELL-1: dc ← 0 and ch ← ch+1.
  - From ch = CH-1, ch ← 0 and wrap = 1 for exactly one cycle.
- Entering SCAN from MANUAL or IDLE:
  - ch ← sel if sel < CH, else 0.
  - dc ← 0.
  - The first scan sample is taken on the entering edge from the loaded ch.
- SCAN→MANUAL: on the edge where mode=0 is seen, sample d[sel] per the MANUAL rules. ch and dc are frozen and discarded; the next scan entry reloads them.
- en=0: all registers hold, including q_valid. wrap is forced to 0 on that edge.
- Arithmetic: ch and dc are unsigned, wrap modulo CH and DWELL respectively. No signed math. dc width = $clog2(DWELL), minimum 1.

## Timing
- Latency: 1 cycle. q/q_sel/q_valid reflect d and sel sampled at the previous rising edge.
- Changes on d between edges do not affect q.
- Scan period: CH*DWELL enabled cycles per full sweep. wrap is asserted on the edge where ch goes 0 after CH-1, i.e. aligned with the first q of channel 0.
- Simultaneous mode change and dwell expiry: the mode change wins. No ch advance, no wrap.
- DWELL=1: ch advances every enabled cycle.
- Reset mid-operation: asynchronous assert clears all outputs immediately. After rst_n release, behaviour restarts from IDLE on the first en=1 edge.

## Test plan
Common setup: WIDTH=4, CH=4, DWELL=2, d=16'hF5A3 (ch0=3, ch1=A, ch2=5, ch3=F).
- Manual sweep: mode=0, en=1, sel=0,1,2,3 (one per cycle) -> q=3,A,5,F with one-cycle lag; q_sel matches; q_valid=1 throughout.
- Scan from sel=2: mode=1 -> q sequence 5,5,F,F,3,3,A,A,5…; wrap=1 only on the first cycle q=3; q_sel follows.
- Enable hold: in scan, drop en for 3 cycles mid-dwell -> q, q_sel, dc frozen; wrap=0; scan resumes with remaining dwell count.
- Out-of-range: CH=3 instance, manual sel=3 -> q=0, q_valid=0; switch to mode=1 with sel=3 -> scan starts at ch0.
- Mode collision: mode 1→0 on the dwell-expiry edge with sel=1 -> q=A, no wrap. Re-entering scan with sel=3 -> q=F,F,3 (wrap)…
- Async reset: assert rst_n=0 between edges during scan -> q=0, q_sel=0, q_valid=0, wrap=0 immediately. After release with en=1, mode=0, sel=1 -> q=A one edge later.
